// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX operand stage: forward-select
// encoding, datapath widths and the ID/EX pipeline register layout.
package id_ex_stage_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
    logic              reg_write;
    logic              is_load;
    fwd_sel_e          fwd_a;
    fwd_sel_e          fwd_b;
  } id_ex_reg_t;

  localparam id_ex_reg_t ID_EX_BUBBLE = '0;

  // x0 is hardwired, so a source naming it never needs a bypass.
  function automatic logic src_live(input logic valid, input logic uses, input logic [4:0] rs);
    return valid && uses && (rs != 5'd0);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decoded-instruction bus from IF/ID into the operand stage, plus the stall
// that freezes PC and IF/ID.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  // id_valid qualifies the id_* fields; while id_stall=1 the stage does not
  // consume them and the producer must present the same instruction again.
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic [XLEN-1:0]   id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic              id_reg_write;
  logic              id_is_load;
  logic              id_stall;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm, id_ctrl,
           id_uses_rs1, id_uses_rs2, id_reg_write, id_is_load,
    input  id_stall
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm, id_ctrl,
           id_uses_rs1, id_uses_rs2, id_reg_write, id_is_load,
    output id_stall
  );

endinterface

// File: rtl/id_ex_stage_fwd_resolve.sv
// Per-source operand resolution: picks the freshest producer among EX, MEM
// and WB for one register read, or flags a load-use hazard.
module fwd_resolve
  import id_ex_stage_pkg::*;
(
  input  logic            live,
  input  logic [4:0]      rs,
  input  logic [XLEN-1:0] rf_val,
  input  logic            ex_valid,
  input  logic            ex_reg_write,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  input  logic [4:0]      mem_rd,
  input  logic            mem_reg_write,
  input  logic            mem_is_load,
  input  logic [XLEN-1:0] mem_result,
  input  logic [4:0]      wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] val,
  output fwd_sel_e        fwd,
  output logic            hazard
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  // Liveness already excludes rs=0, so rd=0 producers can never match.
  assign ex_hit  = live && ex_valid && ex_reg_write && (ex_rd == rs);
  assign mem_hit = live && mem_reg_write && (mem_rd == rs);
  assign wb_hit  = live && wb_reg_write && (wb_rd == rs);

  always_comb begin
    val    = rf_val;
    fwd    = FWD_NONE;
    hazard = 1'b0;
    if (ex_hit) begin
      if (ex_is_load) hazard = 1'b1;
      else            fwd    = FWD_EXMEM;
    end else if (mem_hit) begin
      if (mem_is_load) fwd = FWD_MEMWB;
      else             val = mem_result;
    end else if (wb_hit) begin
      val = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-side operand stage: register-file addressing, MEM/WB bypass,
// load-use stall detection and the ID/EX pipeline register.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  id_ex_stage_if.slave      id,
  output logic [4:0]        rf_a1,
  output logic [4:0]        rf_a2,
  input  logic [XLEN-1:0]   rf_rd1,
  input  logic [XLEN-1:0]   rf_rd2,
  input  logic [4:0]        mem_rd,
  input  logic              mem_reg_write,
  input  logic              mem_is_load,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [4:0]        wb_rd,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_flush,
  input  logic              ex_hold,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_reg_write,
  output logic              ex_is_load,
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b,
  output logic [31:0]       lu_stall_cnt
);

  id_ex_reg_t      ex_q;
  id_ex_reg_t      ex_d;
  logic [31:0]     cnt_q;
  logic            cnt_inc;
  logic [XLEN-1:0] val_a;
  logic [XLEN-1:0] val_b;
  fwd_sel_e        fwd_a;
  fwd_sel_e        fwd_b;
  logic            haz_a;
  logic            haz_b;
  logic            hazard;

  assign rf_a1 = id.id_rs1;
  assign rf_a2 = id.id_rs2;

  fwd_resolve u_res_a (
    .live          (src_live(id.id_valid, id.id_uses_rs1, id.id_rs1)),
    .rs            (id.id_rs1),
    .rf_val        (rf_rd1),
    .ex_valid      (ex_q.valid),
    .ex_reg_write  (ex_q.reg_write),
    .ex_is_load    (ex_q.is_load),
    .ex_rd         (ex_q.rd),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_is_load   (mem_is_load),
    .mem_result    (mem_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_data       (wb_data),
    .val           (val_a),
    .fwd           (fwd_a),
    .hazard        (haz_a)
  );

  fwd_resolve u_res_b (
    .live          (src_live(id.id_valid, id.id_uses_rs2, id.id_rs2)),
    .rs            (id.id_rs2),
    .rf_val        (rf_rd2),
    .ex_valid      (ex_q.valid),
    .ex_reg_write  (ex_q.reg_write),
    .ex_is_load    (ex_q.is_load),
    .ex_rd         (ex_q.rd),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_is_load   (mem_is_load),
    .mem_result    (mem_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_data       (wb_data),
    .val           (val_b),
    .fwd           (fwd_b),
    .hazard        (haz_b)
  );

  // Both sources waiting on the same load still cost a single stall cycle.
  assign hazard      = haz_a || haz_b;
  assign id.id_stall = !ex_flush && (ex_hold || hazard);

  // Priority: flush > hold > load-use bubble > normal advance.
  always_comb begin
    ex_d    = ex_q;
    cnt_inc = 1'b0;
    if (ex_flush) begin
      ex_d = ID_EX_BUBBLE;
    end else if (ex_hold) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d    = ID_EX_BUBBLE;
      cnt_inc = 1'b1;
    end else if (!id.id_valid) begin
      ex_d = ID_EX_BUBBLE;
    end else begin
      ex_d.valid     = 1'b1;
      ex_d.pc        = id.id_pc;
      ex_d.rs1_val   = val_a;
      ex_d.rs2_val   = val_b;
      ex_d.imm       = id.id_imm;
      ex_d.rd        = id.id_rd;
      ex_d.ctrl      = id.id_ctrl;
      ex_d.reg_write = id.id_reg_write;
      ex_d.is_load   = id.id_is_load;
      ex_d.fwd_a     = fwd_a;
      ex_d.fwd_b     = fwd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= ID_EX_BUBBLE;
      cnt_q <= 32'd0;
    end else begin
      ex_q <= ex_d;
      if (cnt_inc) cnt_q <= cnt_q + 32'd1;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_val   = ex_q.rs1_val;
  assign ex_rs2_val   = ex_q.rs2_val;
  assign ex_imm       = ex_q.imm;
  assign ex_rd        = ex_q.rd;
  assign ex_ctrl      = ex_q.ctrl;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_is_load   = ex_q.is_load;
  assign ex_fwd_a     = ex_q.fwd_a;
  assign ex_fwd_b     = ex_q.fwd_b;
  assign lu_stall_cnt = cnt_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-side operand stage of the pipelined core, directly downstream of the register file. Drives the register-file read addresses, bypasses MEM/WB results the register file cannot yet return, detects load-use hazards and stalls decode, and holds the ID/EX pipeline register. Supplies registered forward selects so EX can take results that are not yet available at decode time.

## Interface
- XLEN, 32: datapath width
- CTRL_W, 16: opaque EX control bundle width
- clk in 1: clock
- rst in 1: synchronous active-high reset
- id_valid, id_pc[XLEN], id_rs1[5], id_rs2[5], id_rd[5], id_imm[XLEN], id_ctrl[CTRL_W], id_uses_rs1, id_uses_rs2, id_reg_write, id_is_load in: decoded instruction from IF/ID
- rf_a1, rf_a2 out 5: register-file read addresses (= id_rs1, id_rs2, combinational)
- rf_rd1, rf_rd2 in XLEN: register-file read data
- mem_rd in 5, mem_reg_write in 1, mem_is_load in 1, mem_result in XLEN: instruction in MEM
- wb_rd in 5, wb_reg_write in 1, wb_data in XLEN: instruction in WB (same signals as the rf write port)
- ex_flush in 1: EX branch/jump redirect
- ex_hold in 1: downstream back-pressure
- id_stall out 1: freeze PC and IF/ID (combinational)
- ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_ctrl, ex_reg_write, ex_is_load out: ID/EX register
- ex_fwd_a, ex_fwd_b out 2: 0 = own value, 1 = take EX/MEM result, 2 = take MEM/WB data
- lu_stall_cnt out 32: load-use stall cycles since reset (wraps)

## Operation
- A source is live when id_valid, uses_rsN=1 and rsN≠0. x0 never matches any rd; rd=0 producers are ignored.
- Per live source, priority order:
  - EX match (ex_valid, ex_reg_write, ex_rd=rsN): load → load-use hazard; otherwise fwd=1, value don't-care.
  - MEM match: mem_is_load → fwd=2; otherwise capture mem_result, fwd=0.
  - WB match: capture wb_data, fwd=0 (write-through bypass).
  - Otherwise capture rf_rdN, fwd=0.
- Load-use hazard: id_stall=1; ID/EX loads a bubble (ex_valid=0, ex_reg_write=0); lu_stall_cnt+1. On the next cycle the load is in MEM, giving fwd=2 with no second stall.
- ex_hold=1 (no flush): ID/EX holds all fields; id_stall=1; no counting.
- ex_flush=1: ID/EX loads a bubble; id_stall=0; no counting. Flush overrides hold and hazard.
- Normal advance: id_valid=0 loads a bubble; otherwise all id_* fields are captured with the resolved values and fwd selects.
- Dead sources: fwd=0, value = rf_rdN.

## Timing
- One-cycle latency from ID inputs to ex_*.
- rf_a1/rf_a2 and id_stall are combinational from the current-cycle inputs and the ID/EX register.
- Reset: ex_valid=0, ex_reg_write=0, ex_is_load=0, ex_fwd_a/b=0, all data fields 0, lu_stall_cnt=0.
- Reset mid-stall clears the hazard; id_stall may be nonzero only as a combinational result of live inputs while rst=1.
- Both sources hazarding on the same load: one stall cycle, counted once.
- rs1=rs2 both matching MEM: both get the same selection.
- lu_stall_cnt wraps from 0xFFFFFFFF to 0.

## Structure
- Shared package: FWD_NONE=0, FWD_EXMEM=1, FWD_MEMWB=2; XLEN; CTRL_W.
- One sub-module, fwd_resolve: combinational per-source match/priority logic, instantiated twice (rs1, rs2) and outputting {value, fwd, hazard}.
- Register, stall/flush control and counter live at top level.

## Test plan
- addi x5 in EX, add x6,x5,x1 in ID → no stall; ex_fwd_a=1 next cycle.
- lw x5 in EX, add x6,x5,x5 in ID → id_stall=1 one cycle, bubble, lu_stall_cnt=1; following cycle ex_fwd_a=ex_fwd_b=2.
- WB writes x7=0xDEADBEEF while ID reads x7 with rf_rd1 stale 0 → ex_rs1_val=0xDEADBEEF.
- MEM rd=x3 result 0x11 and WB rd=x3 data 0x22, ID reads x3 → captures 0x11 (MEM priority).
- ex_flush and load-use hazard in the same cycle → bubble, id_stall=0, counter unchanged.
- Producer with rd=x0 and consumer reading x0 → no hazard, value 0; rst during ex_hold → ex_valid=0, lu_stall_cnt=0.
